// File: rtl/cnn_word_fetch.sv
// -----------------------------------------------------------------------------
// cnn_word_fetch
//
// Word-fetch stage that feeds the CNN data-combine stage. An accepted `start`
// reads `num_words` consecutive 32-bit words from a synchronous-read memory,
// beginning at `base_addr`. Each word is presented downstream as an indexed
// word with a one-cycle valid strobe. The block then raises end-of-data
// (`out_f_value_done`). After DONE_DLY further cycles it raises
// end-of-transfer (`out_f_done`), which gives the combiner's pipeline time to
// drain.
//
// Parameters
//   AW        memory word-address width
//   NW_BW     width of num_words and of the word index (<= 32)
//   DONE_DLY  cycles from out_f_value_done rising to out_f_done rising (1..255)
//
// Ports
//   clk, reset_n       clock, asynchronous active-low reset
//   start              one-cycle request, accepted only in IDLE or DONE
//   base_addr          first word address (sampled on accepted start)
//   num_words          word count (sampled on accepted start)
//   mem_en, mem_addr   memory read request
//   mem_rdata          read data, valid one cycle after mem_en
//   out_fmap           current data word
//   out_f_address      0-based word index of out_fmap, zero-extended
//   out_f_valid        new word on out_fmap / out_f_address this cycle
//   out_f_enable       transfer-active level for the downstream pipeline
//   out_f_value_done   all words delivered (level)
//   out_f_done         transfer complete (level)
//   busy               high in READ, DRAIN and FLUSH
// -----------------------------------------------------------------------------
module cnn_word_fetch #(
    parameter int AW       = 16,
    parameter int NW_BW    = 16,
    parameter int DONE_DLY = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [NW_BW-1:0] num_words,
    output logic             mem_en,
    output logic [AW-1:0]    mem_addr,
    input  logic [31:0]      mem_rdata,
    output logic [31:0]      out_fmap,
    output logic [31:0]      out_f_address,
    output logic             out_f_valid,
    output logic             out_f_enable,
    output logic             out_f_value_done,
    output logic             out_f_done,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [7:0]       FLUSH_LAST = 8'(DONE_DLY - 1);
    localparam logic [NW_BW-1:0] NW_ONE     = NW_BW'(1);

    state_t           state_q, state_d;
    logic [AW-1:0]    base_q;
    logic [NW_BW-1:0] num_q;
    logic [NW_BW-1:0] issue_cnt;
    logic [NW_BW-1:0] deliver_cnt;
    logic [NW_BW-1:0] faddr_q;
    logic [7:0]       flush_cnt;
    logic             rd_pending;
    logic             start_ok;
    logic             enter_flush;
    logic             enter_done;

    assign start_ok = start && (state_q == S_IDLE || state_q == S_DONE);

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = (num_words == '0) ? S_FLUSH : S_READ;
                end
            end
            S_READ: begin
                // The last issue happens in this cycle.
                if (issue_cnt == num_q - NW_ONE) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (deliver_cnt == num_q) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (flush_cnt == FLUSH_LAST) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign enter_flush = (state_d == S_FLUSH) && (state_q != S_FLUSH);
    assign enter_done  = (state_d == S_DONE)  && (state_q != S_DONE);

    // NOTE: sequential state uses non-blocking assignments, so every register
    // below samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            base_q           <= '0;
            num_q            <= '0;
            issue_cnt        <= '0;
            deliver_cnt      <= '0;
            faddr_q          <= '0;
            flush_cnt        <= '0;
            rd_pending       <= 1'b0;
            out_fmap         <= '0;
            out_f_valid      <= 1'b0;
            out_f_enable     <= 1'b0;
            out_f_value_done <= 1'b0;
            out_f_done       <= 1'b0;
        end else begin
            state_q <= state_d;

            // Read data comes back one cycle after the request. Clearing this
            // flag on reset discards any read that was in flight.
            rd_pending <= (state_q == S_READ);

            if (state_q == S_READ) begin
                issue_cnt <= issue_cnt + NW_ONE;
            end

            flush_cnt <= (state_q == S_FLUSH) ? flush_cnt + 8'd1 : 8'd0;

            if (rd_pending) begin
                out_fmap     <= mem_rdata;
                faddr_q      <= deliver_cnt;
                out_f_valid  <= 1'b1;
                out_f_enable <= 1'b1;
                deliver_cnt  <= deliver_cnt + NW_ONE;
            end else begin
                out_f_valid <= 1'b0;
            end

            // No read can be pending in IDLE or DONE, so a restart never
            // collides with a delivery.
            if (start_ok) begin
                base_q           <= base_addr;
                num_q            <= num_words;
                issue_cnt        <= '0;
                deliver_cnt      <= '0;
                out_f_enable     <= 1'b0;
                out_f_value_done <= 1'b0;
                out_f_done       <= 1'b0;
            end

            // For a zero-length restart, FLUSH entry coincides with start and
            // must win over the clear above.
            if (enter_flush) begin
                out_f_value_done <= 1'b1;
                out_f_enable     <= 1'b1;
            end

            if (enter_done) begin
                out_f_done <= 1'b1;
            end
        end
    end

    // The address wraps modulo 2^AW.
    assign mem_en        = (state_q == S_READ);
    assign mem_addr      = mem_en ? base_q + AW'(issue_cnt) : '0;
    assign out_f_address = 32'(faddr_q);
    assign busy          = (state_q == S_READ) || (state_q == S_DRAIN) ||
                           (state_q == S_FLUSH);

endmodule

// File: tb/tb_cnn_word_fetch.sv
// -----------------------------------------------------------------------------
// tb_cnn_word_fetch
//
// Directed bench for cnn_word_fetch. A behavioural synchronous-read memory
// answers the fetch requests. Inputs are driven and outputs sampled on the
// falling clock edge. Cycle c of a transfer is the half-cycle after rising
// edge c-1, and start is sampled at edge 0.
// -----------------------------------------------------------------------------
module tb_cnn_word_fetch;

    localparam int DLY = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] num_words;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] out_fmap;
    logic [31:0] out_f_address;
    logic        out_f_valid;
    logic        out_f_enable;
    logic        out_f_value_done;
    logic        out_f_done;
    logic        busy;

    logic [31:0] mem [0:65535];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Synchronous-read memory: data is valid in the cycle after mem_en.
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem[mem_addr];
    end

    cnn_word_fetch #(
        .AW      (16),
        .NW_BW   (16),
        .DONE_DLY(DLY)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .base_addr       (base_addr),
        .num_words       (num_words),
        .mem_en          (mem_en),
        .mem_addr        (mem_addr),
        .mem_rdata       (mem_rdata),
        .out_fmap        (out_fmap),
        .out_f_address   (out_f_address),
        .out_f_valid     (out_f_valid),
        .out_f_enable    (out_f_enable),
        .out_f_value_done(out_f_value_done),
        .out_f_done      (out_f_done),
        .busy            (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " mem_en"},        32'(mem_en),           32'd0);
        check({tag, " mem_addr"},      32'(mem_addr),         32'd0);
        check({tag, " out_fmap"},      out_fmap,              32'd0);
        check({tag, " out_f_address"}, out_f_address,         32'd0);
        check({tag, " out_f_valid"},   32'(out_f_valid),      32'd0);
        check({tag, " out_f_enable"},  32'(out_f_enable),     32'd0);
        check({tag, " value_done"},    32'(out_f_value_done), 32'd0);
        check({tag, " done"},          32'(out_f_done),       32'd0);
        check({tag, " busy"},          32'(busy),             32'd0);
    endtask

    // Runs one transfer and checks every output in every cycle against the
    // timing table. A nonzero ign pulses start at that cycle with junk
    // parameters, and the pulse must be ignored.
    task automatic run_xfer(input logic [15:0] base, input logic [15:0] n,
                            input int ign, input logic [31:0] pat);
        int          done_at;
        int          vdone_at;
        logic        exp_en;
        logic        exp_valid;
        logic [15:0] exp_addr;
        for (int k = 0; k < int'(n); k++) mem[16'(base + k)] = pat + k;
        vdone_at = (n == 0) ? 1 : int'(n) + 3;
        done_at  = vdone_at + DLY;
        @(negedge clk);
        start     = 1'b1;
        base_addr = base;
        num_words = n;
        for (int c = 1; c <= done_at + 1; c++) begin
            @(negedge clk);
            start     = (c == ign);
            base_addr = 16'h0BAD;
            num_words = 16'd3;
            exp_en    = (n != 0) && (c <= int'(n));
            exp_addr  = exp_en ? 16'(base + c - 1) : 16'h0000;
            exp_valid = (n != 0) && (c >= 3) && (c <= int'(n) + 2);
            check($sformatf("mem_en c%0d", c),   32'(mem_en),      32'(exp_en));
            check($sformatf("mem_addr c%0d", c), 32'(mem_addr),    32'(exp_addr));
            check($sformatf("valid c%0d", c),    32'(out_f_valid), 32'(exp_valid));
            if (exp_valid) begin
                check($sformatf("index c%0d", c), out_f_address, 32'(c - 3));
                check($sformatf("data c%0d", c),  out_fmap,      pat + 32'(c - 3));
            end else if (n != 0 && c > int'(n) + 2) begin
                check($sformatf("index hold c%0d", c), out_f_address, 32'(n) - 32'd1);
                check($sformatf("data hold c%0d", c),  out_fmap,      pat + 32'(n) - 32'd1);
            end
            check($sformatf("enable c%0d", c),
                  32'(out_f_enable), 32'((n == 0) || (c >= 3)));
            check($sformatf("value_done c%0d", c),
                  32'(out_f_value_done), 32'(c >= vdone_at));
            check($sformatf("done c%0d", c), 32'(out_f_done), 32'(c >= done_at));
            check($sformatf("busy c%0d", c), 32'(busy),       32'(c < done_at));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        base_addr = 16'h0000;
        num_words = 16'h0000;
        for (int a = 0; a < 65536; a++) mem[a] = 32'hDEAD0000 | a;

        // Reset values, then 10 idle cycles with no memory activity.
        repeat (3) @(negedge clk);
        check_all_zero("in reset");
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("idle mem_en c%0d", c), 32'(mem_en), 32'd0);
        end
        check_all_zero("idle");

        // Basic 8-word transfer with a start pulse at cycle 5 that must be ignored.
        run_xfer(16'h0010, 16'd8, 5, 32'hA500_0000);

        // Restart from DONE with an address wrap.
        run_xfer(16'hFFFE, 16'd4, 0, 32'h5A00_0000);

        // Zero-length transfer from DONE.
        run_xfer(16'h0040, 16'd0, 0, 32'h0000_0000);

        // Reset mid-transfer aborts asynchronously.
        for (int k = 0; k < 8; k++) mem[16'h0080 + k] = 32'h7700_0000 + k;
        @(negedge clk);
        start     = 1'b1;
        base_addr = 16'h0080;
        num_words = 16'd8;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre-reset mem_en", 32'(mem_en), 32'd1);
        check("pre-reset valid",  32'(out_f_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1 check_all_zero("async reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_all_zero("after reset");

        // A fresh 2-word transfer delivers only its own words.
        run_xfer(16'h00C0, 16'd2, 0, 32'h3C00_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cnn_word_fetch.md
# cnn_word_fetch

Word-fetch stage directly upstream of the CNN data-combine stage. On `start`, reads `num_words` consecutive 32-bit words from a synchronous-read on-chip memory holding packed feature-map, weight and bias data. It presents the words to the combiner as an indexed word stream with enable/valid strobes. It then signals end-of-data (`out_f_value_done`) and, after a programmable flush delay, end-of-transfer (`out_f_done`), so the combiner's internal pipeline drains before its outputs are gated through.

## Interface
- `AW`, 16: memory word-address width.
- `NW_BW`, 16: width of `num_words` and of the word index.
- `DONE_DLY`, 4: cycles between `out_f_value_done` rising and `out_f_done` rising. Legal range 1..255.

- `clk`  in  1  single clock for the whole block.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request. Accepted only in IDLE or DONE.
- `base_addr`  in  AW  first word address. Sampled on accepted `start`.
- `num_words`  in  NW_BW  word count. Sampled on accepted `start`.
- `mem_en`  out  1  memory read enable.
- `mem_addr`  out  AW  memory word address.
- `mem_rdata`  in  32  read data, valid exactly 1 cycle after `mem_en`.
- `out_fmap`  out  32  current data word.
- `out_f_address`  out  32  word index (0-based) of `out_fmap`, zero-extended.
- `out_f_valid`  out  1  `out_fmap` / `out_f_address` hold a new word this cycle.
- `out_f_enable`  out  1  transfer-active level for the downstream pipeline.
- `out_f_value_done`  out  1  all words delivered (level).
- `out_f_done`  out  1  transfer complete, downstream may consume (level).
- `busy`  out  1  high in any state other than IDLE/DONE.

## Operation
- FSM states: IDLE, READ, DRAIN, FLUSH, DONE.
- IDLE -> READ on `start`. `base_addr` and `num_words` are latched, and the issue and delivery counters are cleared.
- IDLE -> FLUSH on `start` with `num_words`=0. No reads and no `out_f_valid`.
- READ: `mem_en`=1 every cycle. `mem_addr`=latched base + issue count, modulo 2^AW (wrap-around permitted, no error). After the Nth issue, the FSM moves to DRAIN.
- DRAIN: `mem_en`=0. Waits until the delivery counter equals N, then moves to FLUSH.
- FLUSH: counts DONE_DLY cycles, then moves to DONE.
- DONE: holds until `start`. A new `start` clears `out_f_enable`, `out_f_value_done` and `out_f_done` in the same edge and enters READ (or FLUSH if N=0).
- Delivery: each `mem_rdata` return is registered into `out_fmap`, with `out_f_address` set to the delivery count and `out_f_valid`=1 for one cycle. The delivery count then increments.
- `out_fmap` and `out_f_address` hold their last value when `out_f_valid`=0.
- `out_f_enable`: set together with the first `out_f_valid`, or on entry to FLUSH if N=0. It stays high through FLUSH and DONE, and clears only on the next accepted `start` or on reset.
- `out_f_value_done`: set on FLUSH entry and held until next `start`.
- `out_f_done`: set on DONE entry and held until next `start`.
- `start` in READ, DRAIN or FLUSH is ignored, with no effect on the latched parameters.

## Timing
- Reset: state IDLE. `mem_en`, `mem_addr`, `out_fmap`, `out_f_address`, `out_f_valid`, `out_f_enable`, `out_f_value_done`, `out_f_done` and `busy` are all 0. Reset asserted mid-transfer aborts immediately. A read returning after reset is discarded.
- With `start` sampled at edge 0:
  - `mem_en`/`mem_addr` for word k are high at cycle k+1.
  - `mem_rdata` for word k is valid at cycle k+2.
  - `out_f_valid` with word k is high at cycle k+3. The latency from `start` to the first word is 3 cycles, and throughput is 1 word/cycle with no gaps.
- Last word at cycle N+2. `out_f_value_done`=1 from cycle N+3. `out_f_done`=1 from cycle N+3+DONE_DLY.
- N=0: `out_f_enable` and `out_f_value_done` are 1 from cycle 1, and `out_f_done` is 1 from cycle 1+DONE_DLY.
- `busy` is high from cycle 1 until `out_f_done` rises.

## Test plan
- **Reset values:** reset, then idle 10 cycles -> every output 0, `mem_en` never asserted.
- **Basic 8-word transfer:** memory[k]=0xA5000000+k, `base_addr`=0x0010, N=8, DONE_DLY=4.
  - `mem_addr` 0x0010..0x0017 at cycles 1..8.
  - `out_f_valid` at cycles 3..10 with `out_f_address` 0..7 and data 0xA5000000..0xA5000007.
  - `out_f_value_done` rises at cycle 11, `out_f_done` at cycle 15.
- **Address wrap:** AW=16, `base_addr`=0xFFFE, N=4 -> `mem_addr` sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001. Data delivered in that order with indices 0..3.
- **Ignored and restart `start`:** `start` pulsed again at cycle 5 of an N=8 transfer -> no change in behaviour. `start` in DONE -> `out_f_done`, `out_f_value_done` and `out_f_enable` go low next cycle, and a new transfer begins with index 0.
- **Zero-length transfer:** N=0 -> no `mem_en`, no `out_f_valid`. `out_f_value_done` rises at cycle 1, `out_f_done` at cycle 5.
- **Reset mid-transfer:** `reset_n` low at cycle 6 of an N=8 transfer -> all outputs 0 asynchronously. After release, a fresh N=2 transfer delivers only its own two words, indices 0..1.
